// File: rtl/ahb_pkg.sv
// Shared AHB transfer encodings and master identifiers for the two-master mux.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic MID_M0 = 1'b0;
  localparam logic MID_M1 = 1'b1;

  // NONSEQ and SEQ carry a transfer; IDLE and BUSY do not.
  function automatic logic is_xfer(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_master_mux2_if.sv
// Bus bundle between two AHB masters, the mux and one slave.
// 'slave' is the mux's view of the bundle; 'master' is the surrounding masters/slave.
interface ahb_master_mux2_if #(parameter int AW = 32);
  logic [AW-1:0] M0_HADDR;
  logic [1:0]    M0_HTRANS;
  logic          M0_HWRITE;
  logic [2:0]    M0_HSIZE;
  logic [31:0]   M0_HWDATA;
  logic          M0_HREADY;
  logic [31:0]   M0_HRDATA;
  logic [AW-1:0] M1_HADDR;
  logic [1:0]    M1_HTRANS;
  logic          M1_HWRITE;
  logic [2:0]    M1_HSIZE;
  logic [31:0]   M1_HWDATA;
  logic          M1_HREADY;
  logic [31:0]   M1_HRDATA;
  logic [AW-1:0] S_HADDR;
  logic [1:0]    S_HTRANS;
  logic          S_HWRITE;
  logic [2:0]    S_HSIZE;
  logic [31:0]   S_HWDATA;
  logic          S_HREADY;
  logic [31:0]   S_HRDATA;
  logic          HMASTER;

  modport slave (
    input  M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HWDATA,
    input  M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HWDATA,
    input  S_HREADY, S_HRDATA,
    output M0_HREADY, M0_HRDATA, M1_HREADY, M1_HRDATA,
    output S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HWDATA, HMASTER
  );

  modport master (
    output M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HWDATA,
    output M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HWDATA,
    output S_HREADY, S_HRDATA,
    input  M0_HREADY, M0_HRDATA, M1_HREADY, M1_HRDATA,
    input  S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HWDATA, HMASTER
  );
endinterface

// File: rtl/ahb_input_stage.sv
// Per-master hold register: parks a live request the arbiter could not accept
// and replays it to the slave side until it is accepted.
module ahb_input_stage
  import ahb_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic [AW-1:0] i_haddr,
  input  logic [1:0]    i_htrans,
  input  logic          i_hwrite,
  input  logic [2:0]    i_hsize,
  input  logic          i_ready_nohold,
  input  logic          i_accept,
  output logic          o_req,
  output logic [AW-1:0] o_haddr,
  output logic [1:0]    o_htrans,
  output logic          o_hwrite,
  output logic [2:0]    o_hsize,
  output logic          o_hready
);

  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_trans;
  logic          r_write;
  logic [2:0]    r_size;
  logic          w_live;

  // Live inputs only count when nothing is parked and the master was told ready.
  assign w_live = ~r_valid & is_xfer(i_htrans) & i_ready_nohold;
  assign o_req  = r_valid | w_live;

  always_comb begin
    o_haddr  = i_haddr;
    o_htrans = i_htrans;
    o_hwrite = i_hwrite;
    o_hsize  = i_hsize;
    if (r_valid) begin
      o_haddr  = r_addr;
      o_htrans = r_trans;
      o_hwrite = r_write;
      o_hsize  = r_size;
    end else begin
      o_haddr  = i_haddr;
      o_htrans = i_htrans;
      o_hwrite = i_hwrite;
      o_hsize  = i_hsize;
    end
  end

  always_comb begin
    o_hready = 1'b1;
    if (HRESET) begin
      o_hready = 1'b1;
    end else if (r_valid) begin
      o_hready = i_accept;
    end else begin
      o_hready = i_ready_nohold;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_trans <= 2'd0;
      r_write <= 1'b0;
      r_size  <= 3'd0;
    end else if (r_valid) begin
      r_valid <= ~i_accept;
    end else if (w_live && !i_accept) begin
      r_valid <= 1'b1;
      r_addr  <= i_haddr;
      r_trans <= i_htrans;
      r_write <= i_hwrite;
      r_size  <= i_hsize;
    end else begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ahb_master_mux2.sv
// Two-master AHB-Lite mux: fixed-priority arbitration with wait-state freeze and
// burst retention, zero-latency pass-through, and data-phase routing.
module ahb_master_mux2
  import ahb_pkg::*;
#(
  parameter int AW      = 32,
  parameter bit M1_HIGH = 1'b1
) (
  input logic              HCLK,
  input logic              HRESET,
  ahb_master_mux2_if.slave bus
);

  localparam logic HI_ID = M1_HIGH ? MID_M1 : MID_M0;
  localparam logic LO_ID = M1_HIGH ? MID_M0 : MID_M1;

  logic          r_grant, r_freeze, r_rst_d, r_dp_valid, r_dp_owner;
  logic          w_block, w_rdy0, w_rdy1, w_req0, w_req1, w_acc0, w_acc1;
  logic [AW-1:0] w_addr0, w_addr1;
  logic [1:0]    w_trans0, w_trans1, w_g_trans, w_own_trans;
  logic          w_write0, w_write1, w_g_req, w_own_req, w_req_hi, w_req_lo;
  logic [2:0]    w_size0, w_size1;
  logic          w_grant;

  // The first cycle after reset release behaves like reset on the slave side.
  assign w_block = HRESET | r_rst_d;
  assign w_rdy0  = ~(r_dp_valid & (r_dp_owner == MID_M0)) | bus.S_HREADY;
  assign w_rdy1  = ~(r_dp_valid & (r_dp_owner == MID_M1)) | bus.S_HREADY;

  ahb_input_stage #(.AW(AW)) u_in0 (
    .HCLK(HCLK), .HRESET(HRESET),
    .i_haddr(bus.M0_HADDR), .i_htrans(bus.M0_HTRANS), .i_hwrite(bus.M0_HWRITE),
    .i_hsize(bus.M0_HSIZE), .i_ready_nohold(w_rdy0), .i_accept(w_acc0),
    .o_req(w_req0), .o_haddr(w_addr0), .o_htrans(w_trans0), .o_hwrite(w_write0),
    .o_hsize(w_size0), .o_hready(bus.M0_HREADY)
  );

  ahb_input_stage #(.AW(AW)) u_in1 (
    .HCLK(HCLK), .HRESET(HRESET),
    .i_haddr(bus.M1_HADDR), .i_htrans(bus.M1_HTRANS), .i_hwrite(bus.M1_HWRITE),
    .i_hsize(bus.M1_HSIZE), .i_ready_nohold(w_rdy1), .i_accept(w_acc1),
    .o_req(w_req1), .o_haddr(w_addr1), .o_htrans(w_trans1), .o_hwrite(w_write1),
    .o_hsize(w_size1), .o_hready(bus.M1_HREADY)
  );

  assign w_req_hi    = (HI_ID == MID_M1) ? w_req1 : w_req0;
  assign w_req_lo    = (LO_ID == MID_M1) ? w_req1 : w_req0;
  assign w_own_req   = (r_grant == MID_M1) ? w_req1 : w_req0;
  assign w_own_trans = (r_grant == MID_M1) ? w_trans1 : w_trans0;

  always_comb begin
    w_grant = r_grant;
    if (w_block) begin
      w_grant = LO_ID;
    end else if (r_freeze || (w_own_req && (w_own_trans == HTRANS_SEQ))) begin
      w_grant = r_grant;
    end else if (w_req_hi) begin
      w_grant = HI_ID;
    end else if (w_req_lo) begin
      w_grant = LO_ID;
    end else begin
      w_grant = r_grant;
    end
  end

  assign w_acc0 = ~w_block & (w_grant == MID_M0) & bus.S_HREADY & w_req0;
  assign w_acc1 = ~w_block & (w_grant == MID_M1) & bus.S_HREADY & w_req1;

  always_comb begin
    bus.S_HADDR  = w_addr0;
    bus.S_HWRITE = w_write0;
    bus.S_HSIZE  = w_size0;
    w_g_trans    = w_trans0;
    w_g_req      = w_req0;
    if (w_grant == MID_M1) begin
      bus.S_HADDR  = w_addr1;
      bus.S_HWRITE = w_write1;
      bus.S_HSIZE  = w_size1;
      w_g_trans    = w_trans1;
      w_g_req      = w_req1;
    end else begin
      bus.S_HADDR  = w_addr0;
      bus.S_HWRITE = w_write0;
      bus.S_HSIZE  = w_size0;
      w_g_trans    = w_trans0;
      w_g_req      = w_req0;
    end
    bus.S_HTRANS = (w_g_req && !w_block) ? w_g_trans : HTRANS_IDLE;
  end

  assign bus.HMASTER   = w_grant;
  assign bus.S_HWDATA  = (r_dp_owner == MID_M1) ? bus.M1_HWDATA : bus.M0_HWDATA;
  assign bus.M0_HRDATA = bus.S_HRDATA;
  assign bus.M1_HRDATA = bus.S_HRDATA;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_grant    <= LO_ID;
      r_freeze   <= 1'b0;
      r_rst_d    <= 1'b1;
      r_dp_valid <= 1'b0;
      r_dp_owner <= MID_M0;
    end else begin
      r_grant  <= w_grant;
      r_freeze <= ~bus.S_HREADY & is_xfer(bus.S_HTRANS);
      r_rst_d  <= 1'b0;
      if (w_acc0 || w_acc1) begin
        r_dp_valid <= 1'b1;
        r_dp_owner <= w_acc1 ? MID_M1 : MID_M0;
      end else if (bus.S_HREADY) begin
        r_dp_valid <= 1'b0;
      end else begin
        r_dp_valid <= r_dp_valid;
      end
    end
  end

endmodule
